// File: rtl/neuron_driver.sv
// Upstream sequencer for a single neuron: serial operand load, start strobe,
// result capture with watchdog, and valid/ready presentation of the activation.
module neuron_driver #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_INPUTS     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] inputs [NUM_INPUTS],
    output logic                         input_ready,
    input  logic signed [DATA_WIDTH-1:0] neuron_out,
    input  logic                         output_ready,
    output logic signed [DATA_WIDTH-1:0] result,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic                         busy,
    output logic                         timeout
);

    localparam int CW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0] LAST_IDX  = CW'(NUM_INPUTS - 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] LOADING     = 2'd0;
    localparam logic [1:0] START       = 2'd1;
    localparam logic [1:0] WAIT_RESULT = 2'd2;
    localparam logic [1:0] PRESENT     = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [CW-1:0] count;
    logic [WW-1:0] wdog;
    logic          in_ready_q;
    logic          accept;
    logic          wdog_expired;

    // in_ready is its own flop so it is low during reset yet still state-derived.
    assign accept       = in_valid && in_ready_q;
    assign wdog_expired = (wdog == WDOG_LAST);

    always_comb begin
        state_next = state;
        case (state)
            LOADING:     if (accept && (count == LAST_IDX)) state_next = START;
            START:       state_next = WAIT_RESULT;
            WAIT_RESULT: if (output_ready || wdog_expired) state_next = PRESENT;
            PRESENT:     if (result_ready) state_next = LOADING;
            default:     state_next = LOADING;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= LOADING;
            count      <= '0;
            wdog       <= '0;
            result     <= '0;
            timeout    <= 1'b0;
            in_ready_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                inputs[i] <= '0;
            end
        end else begin
            state      <= state_next;
            in_ready_q <= (state_next == LOADING);

            if ((state == LOADING) && accept) begin
                inputs[count] <= in_data;
                count         <= (count == LAST_IDX) ? '0 : count + 1'b1;
            end

            // output_ready has priority over a watchdog expiry in the same cycle.
            if (state == WAIT_RESULT) begin
                wdog <= wdog + 1'b1;
                if (output_ready) begin
                    result <= neuron_out;
                end else if (wdog_expired) begin
                    timeout <= 1'b1;
                    result  <= '0;
                end
            end else begin
                wdog <= '0;
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign input_ready  = (state == START);
    assign result_valid = (state == PRESENT);
    assign busy         = (state != LOADING);

endmodule

// File: doc/neuron_driver.md
# neuron_driver

Upstream sequencer for a single `neuron` instance; it initiates the neuron's `input_ready`/`output_ready` exchange and collects the result. It accepts a serial stream of `NUM_INPUTS` signed operands over a valid/ready handshake and assembles them into the neuron's parallel `inputs` array. It then pulses `input_ready`, waits for `output_ready`, captures the activation value and presents it downstream on a valid/ready handshake. A watchdog flags a neuron that never completes.

## Interface
- `DATA_WIDTH`, 32: operand/result width, signed two's complement.
- `NUM_INPUTS`, 16: operands per neuron evaluation, ≥2.
- `TIMEOUT_CYCLES`, 64: watchdog limit in cycles; must be > `NUM_INPUTS`+3.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `in_data`  in  DATA_WIDTH  signed operand from upstream.
- `in_valid`  in  1  upstream has an operand.
- `in_ready`  out  1  driver accepts an operand.
- `inputs`  out  DATA_WIDTH × NUM_INPUTS  unpacked array to neuron `inputs`.
- `input_ready`  out  1  start strobe to neuron.
- `neuron_out`  in  DATA_WIDTH  neuron `out`.
- `output_ready`  in  1  neuron done strobe.
- `result`  out  DATA_WIDTH  captured activation.
- `result_valid`  out  1  `result` is valid.
- `result_ready`  in  1  downstream accepts `result`.
- `busy`  out  1  high in any state other than LOADING.
- `timeout`  out  1  sticky watchdog flag.

## Operation
- States: LOADING, START, WAIT_RESULT, PRESENT.
- **LOADING**
  - `in_ready`=1. An operand is accepted only on a cycle with `in_valid`&&`in_ready`.
  - Accepted operand → `inputs[count]`, then `count`++ (width $clog2(NUM_INPUTS)).
  - The accept at `count`==NUM_INPUTS-1 → START, `count`←0.
- **START**
  - `input_ready`=1 for exactly this one cycle, then → WAIT_RESULT.
  - `in_ready`=0 in START, WAIT_RESULT and PRESENT.
- **WAIT_RESULT**
  - `wdog` counter starts at 0 on entry and increments each cycle.
  - `output_ready`=1 → `result`←`neuron_out`, → PRESENT.
  - Otherwise, when `wdog`==TIMEOUT_CYCLES-1 → `timeout`←1, `result`←0, → PRESENT.
- **PRESENT**
  - `result_valid`=1, and `result` is held stable.
  - `result_ready`=1 → `result_valid`←0, → LOADING.
- `inputs` change only on accepted LOADING handshakes. They are therefore stable from START through the neuron's multiply cycle and beyond.
- `output_ready` outside WAIT_RESULT is ignored; it causes no capture and no state change.
- `result` passes through bit-exact from `neuron_out` (signed DATA_WIDTH); no saturation or rescaling.
- `timeout` is cleared only by `reset`.

## Timing
- **Reset values (asynchronous):**
  - state=LOADING, `count`=0, `wdog`=0.
  - All `inputs`=0, `result`=0.
  - `result_valid`=0, `input_ready`=0, `timeout`=0, `busy`=0.
  - `in_ready` is forced 0 while `reset` is high.
- `in_ready`, `input_ready`, `result_valid` and `busy` are decoded from registered state only. They have no combinational path from any input.
- **Load:** minimum NUM_INPUTS cycles, back-to-back at one operand per cycle.
- **START:** occurs in the cycle after the final accept.
- **Neuron latency:** with a conforming neuron, `output_ready` arrives NUM_INPUTS+3 cycles after the START cycle (19 cycles at default).
- **Capture:** `result_valid` rises on the cycle after `output_ready`.
- **Minimum period:** NUM_INPUTS + 1 + (NUM_INPUTS+3) + 1 + 1 = 2·NUM_INPUTS+6 cycles per evaluation when `result_ready` is held high.
- **Simultaneous events:**
  - `output_ready` and watchdog expiry in the same cycle: `output_ready` wins, `timeout` stays 0.
  - `result_ready` asserted in the first PRESENT cycle is honoured; the driver returns to LOADING the next cycle.
- **Reset mid-operation** (any state):
  - Immediate return to reset values; a partial load is discarded.
  - A neuron still mid-evaluation is assumed reset by the same `reset` net.
- `input_ready` is never asserted twice per evaluation. It is never asserted while `result_valid`=1.

## Test plan
- **Basic evaluation:** reset, then stream 1..16 back-to-back with a neuron model returning 100 at START+19.
  - Expect `inputs[i]`=i+1 and one `input_ready` pulse the cycle after the 16th accept.
  - Expect `result`=100 with `result_valid` the following cycle, and `timeout`=0.
- **Gapped input:** `in_valid` toggling 1,0,0,1,… over the 16 operands.
  - Expect `count` to advance only on handshakes and final `inputs` identical to the basic scenario.
- **Backpressure:** hold `result_ready`=0 for 10 cycles in PRESENT, with `in_valid`=1 throughout.
  - Expect `result`/`result_valid` stable, `in_ready`=0, no `input_ready`, and LOADING the cycle after `result_ready`=1.
- **Timeout:** neuron model never asserts `output_ready`.
  - After 64 WAIT_RESULT cycles expect `timeout`=1, `result`=0, `result_valid`=1.
  - A late `output_ready` in PRESENT is ignored.
- **Reset mid-load:** assert `reset` after 7 accepts of value 0x7FFFFFFF.
  - Expect all outputs at reset values asynchronously; the next 16 operands land at indices 0..15.
- **Coincident events:** `output_ready` (`neuron_out`=-5) in the same cycle as watchdog expiry.
  - Expect `result`=-5 (0xFFFFFFFB) and `timeout`=0.
